multi_sum_pipe: RTL and testbench

//  Parametrised, pipelined multi-operand adder; successor to the 3x4-bit combinational sum.

---
 rtl/multi_sum_pkg.sv | 19 +
 rtl/multi_sum_stage.sv | 67 ++++++
 rtl/multi_sum_pipe.sv | 106 ++++++++++
 tb/tb_multi_sum_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_sum_pkg.sv
// Shared sizing helpers for the pipelined multi-operand adder tree.
// Latency: n/a (types and constant functions only); backpressure: n/a.
package multi_sum_pkg;

    localparam int CNT_W = 16;

    // Number of tree levels, which is also the pipeline depth (at least one register stage).
    function automatic int levels(input int n);
        int c;
        c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

    // Terms remaining after l pairing levels: ceil(n / 2^l).
    function automatic int terms_at(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/multi_sum_stage.sv
// One adder-tree level: adds adjacent term pairs (2i, 2i+1); an odd last term is registered as-is.
// Latency 1 cycle; every register holds while advance is low, rst clears all state.
// Backpressure: none locally, the shared advance from the top freezes the whole tree.
module multi_sum_stage
    import multi_sum_pkg::*;
#(
    parameter int  IN_TERMS  = 3,
    parameter int  OUT_W     = 6,
    localparam int OUT_TERMS = terms_at(IN_TERMS, 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       in_vld,
    input  logic                       in_sgn,
    input  logic [IN_TERMS*OUT_W-1:0]  in_dat,
    output logic                       out_vld,
    output logic                       out_sgn,
    output logic [OUT_TERMS*OUT_W-1:0] out_dat
);

    logic [OUT_TERMS*OUT_W-1:0] pair_sum;

    for (genvar i = 0; i < OUT_TERMS; i++) begin : g_pair
        if (2*i + 1 < IN_TERMS) begin : g_add
            assign pair_sum[i*OUT_W +: OUT_W] = in_dat[2*i*OUT_W +: OUT_W]
                                              + in_dat[(2*i+1)*OUT_W +: OUT_W];
        end else begin : g_pass
            assign pair_sum[i*OUT_W +: OUT_W] = in_dat[2*i*OUT_W +: OUT_W];
        end
    end

    logic [OUT_TERMS*OUT_W-1:0] dat_d, dat_q;
    logic                       vld_d, vld_q;
    logic                       sgn_d, sgn_q;

    // Bubbles only clear the valid bit; data and flag keep their last value.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        sgn_d = sgn_q;
        if (advance) begin
            vld_d = in_vld;
            if (in_vld) begin
                dat_d = pair_sum;
                sgn_d = in_sgn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q <= '0;
            vld_q <= 1'b0;
            sgn_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
            sgn_q <= sgn_d;
        end
    end

    assign out_dat = dat_q;
    assign out_vld = vld_q;
    assign out_sgn = sgn_q;

endmodule

// File: rtl/multi_sum_pipe.sv
// Pipelined NUM_OPS x WIDTH adder tree, signed/unsigned per transaction; MULTI_SUM_PIPE_COUNT_EN adds txn_count.
// Latency LEVELS cycles, one result per cycle when out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a stall freezes every stage together.
module multi_sum_pipe
    import multi_sum_pkg::*;
#(
    parameter int  WIDTH   = 4,
    parameter int  NUM_OPS = 3,
    localparam int OUT_W   = WIDTH + $clog2(NUM_OPS),
    localparam int LEVELS  = levels(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic                     in_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_sum
`ifdef MULTI_SUM_PIPE_COUNT_EN
    ,
    output logic [CNT_W-1:0]         txn_count
`endif
);

    logic                     advance;
    logic [NUM_OPS*OUT_W-1:0] ext_ops;
    logic                     last_sgn_unused;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Widening up front keeps every add OUT_W wide and the result exact in both modes.
    always_comb begin
        ext_ops = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            ext_ops[k*OUT_W +: OUT_W] = in_signed ? OUT_W'($signed(in_ops[k*WIDTH +: WIDTH]))
                                                  : OUT_W'(in_ops[k*WIDTH +: WIDTH]);
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_T  = terms_at(NUM_OPS, l);
        localparam int OUT_T = terms_at(NUM_OPS, l + 1);

        logic [IN_T*OUT_W-1:0]  dat_in;
        logic                   vld_in;
        logic                   sgn_in;
        logic [OUT_T*OUT_W-1:0] dat_out;
        logic                   vld_out;
        logic                   sgn_out;

        if (l == 0) begin : g_head
            assign dat_in = ext_ops;
            assign vld_in = in_valid;
            assign sgn_in = in_signed;
        end else begin : g_link
            assign dat_in = g_lvl[l-1].dat_out;
            assign vld_in = g_lvl[l-1].vld_out;
            assign sgn_in = g_lvl[l-1].sgn_out;
        end

        multi_sum_stage #(
            .IN_TERMS (IN_T),
            .OUT_W    (OUT_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .advance (advance),
            .in_vld  (vld_in),
            .in_sgn  (sgn_in),
            .in_dat  (dat_in),
            .out_vld (vld_out),
            .out_sgn (sgn_out),
            .out_dat (dat_out)
        );
    end

    // The tree always narrows to a single term at the last level.
    assign out_valid       = g_lvl[LEVELS-1].vld_out;
    assign out_sum         = g_lvl[LEVELS-1].dat_out[OUT_W-1:0];
    assign last_sgn_unused = g_lvl[LEVELS-1].sgn_out;

`ifdef MULTI_SUM_PIPE_COUNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign txn_count = cnt_q;
`endif

endmodule

// File: tb/tb_multi_sum_pipe.sv
// Bench for multi_sum_pipe: a 3x4-bit instance with a scoreboard, plus a 5x8-bit instance.
module tb_multi_sum_pipe;

    localparam int A_W  = 4;
    localparam int A_N  = 3;
    localparam int A_OW = 6;
    localparam int B_W  = 8;
    localparam int B_N  = 5;
    localparam int B_OW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                 a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
    logic [A_N*A_W-1:0]   a_in_ops;
    logic [A_OW-1:0]      a_out_sum;
    logic                 b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
    logic [B_N*B_W-1:0]   b_in_ops;
    logic [B_OW-1:0]      b_out_sum;
`ifdef MULTI_SUM_PIPE_COUNT_EN
    logic [15:0]          a_txn_count, b_txn_count;
`endif

    multi_sum_pipe #(.WIDTH(A_W), .NUM_OPS(A_N)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_ops    (a_in_ops),
        .in_signed (a_in_signed),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum)
`ifdef MULTI_SUM_PIPE_COUNT_EN
        ,
        .txn_count (a_txn_count)
`endif
    );

    multi_sum_pipe #(.WIDTH(B_W), .NUM_OPS(B_N)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_ops    (b_in_ops),
        .in_signed (b_in_signed),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum)
`ifdef MULTI_SUM_PIPE_COUNT_EN
        ,
        .txn_count (b_txn_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: interpret each operand as a plain integer, add, keep OUT_W bits.
    function automatic longint ref_sum(input logic [63:0] ops, input logic sgn,
                                       input int w, input int n, input int ow);
        longint s, v, m;
        s = 0;
        m = (longint'(1) << w) - 1;
        for (int k = 0; k < n; k++) begin
            v = longint'(ops >> (k*w)) & m;
            if (sgn && v >= (longint'(1) << (w-1))) v = v - (longint'(1) << w);
            s = s + v;
        end
        return s & ((longint'(1) << ow) - 1);
    endfunction

    function automatic logic [11:0] pk3(input int x0, input int x1, input int x2);
        return {4'(x2), 4'(x1), 4'(x0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance A: expected results queued at accept, checked while valid.
    longint a_q[$];
    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
        end else begin
            if (a_out_valid) begin
                chk("a_out_pending", a_q.size() > 0, 1);
                if (a_q.size() > 0) begin
                    chk("a_out_sum", a_out_sum, a_q[0]);
                    if (a_out_ready) void'(a_q.pop_front());
                end
            end
            if (a_in_valid && a_in_ready)
                a_q.push_back(ref_sum(64'(a_in_ops), a_in_signed, A_W, A_N, A_OW));
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (cyc > 95000) begin
            $display("FAIL watchdog: got %0d cycles expected under 95000", cyc);
            $fatal(1, "bench did not complete");
        end
    end

    task automatic a_one(input string tag, input logic [11:0] ops, input logic sgn, input longint exp);
        a_in_ops = ops; a_in_signed = sgn; a_in_valid = 1'b1; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk({tag, "_early"}, a_out_valid, 0);
        tick();
        chk({tag, "_vld"}, a_out_valid, 1);
        chk({tag, "_sum"}, a_out_sum, exp);
        tick();
    endtask

    task automatic b_one(input string tag, input logic [39:0] ops, input logic sgn, input longint exp);
        b_in_ops = ops; b_in_signed = sgn; b_in_valid = 1'b1; b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk({tag, "_early1"}, b_out_valid, 0);
        tick();
        chk({tag, "_early2"}, b_out_valid, 0);
        tick();
        chk({tag, "_vld"}, b_out_valid, 1);
        chk({tag, "_sum"}, b_out_sum, exp);
        tick();
    endtask

    initial begin
        logic [39:0] bops;
        logic        bsg;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_ops = '0; a_in_signed = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_ops = '0; b_in_signed = 1'b0; b_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_ops = pk3(5, 5, 5);
        repeat (3) tick();
        chk("rst_a_vld", a_out_valid, 0);
        chk("rst_a_sum", a_out_sum, 0);
        chk("rst_b_vld", b_out_valid, 0);
        chk("rst_b_sum", b_out_sum, 0);
        chk("rst_a_rdy", a_in_ready, 1);
`ifdef MULTI_SUM_PIPE_COUNT_EN
        chk("rst_cnt", b_txn_count, 0);
`endif
        a_in_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Latency and exactness in both modes
        a_one("t1_max_u", pk3(15, 15, 15), 1'b0, 45);
        a_one("t2_min_s", pk3(8, 8, 8), 1'b1, 40);
        a_one("t2_mix_s", pk3(7, 15, 0), 1'b1, 6);

        // Back-to-back stream
        a_in_signed = 1'b0; a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_ops = pk3(1, 2, 3);
        tick();
        a_in_ops = pk3(4, 5, 6);
        tick();
        chk("t3_r0", a_out_sum, 6);
        a_in_ops = pk3(15, 0, 1);
        tick();
        chk("t3_r1", a_out_sum, 15);
        a_in_valid = 1'b0;
        tick();
        chk("t3_r2", a_out_sum, 16);
        chk("t3_r2_vld", a_out_valid, 1);
        tick();
        chk("t3_idle", a_out_valid, 0);

        // Stall with continuous offers
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_ops = pk3(3, 4, 5);
        tick();
        a_in_ops = pk3(9, 9, 9);
        tick();
        a_in_ops = pk3(15, 14, 13);
        for (int i = 0; i < 3; i++) begin
            chk("t4_rdy_low", a_in_ready, 0);
            chk("t4_hold_vld", a_out_valid, 1);
            chk("t4_hold_sum", a_out_sum, 12);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        chk("t4_rdy_rel", a_in_ready, 1);
        tick();
        chk("t4_rel0", a_out_sum, 27);
        a_in_ops = pk3(1, 0, 0);
        tick();
        chk("t4_rel1", a_out_sum, 42);
        a_in_valid = 1'b0;
        tick();
        chk("t4_rel2", a_out_sum, 1);
        tick();
        chk("t4_drained", a_out_valid, 0);

        // Reset mid-flight
        a_in_valid = 1'b1; a_in_ops = pk3(1, 1, 1); a_in_signed = 1'b0;
        tick();
        a_in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("t5_drop0", a_out_valid, 0);
        rst = 1'b0;
        tick();
        chk("t5_drop1", a_out_valid, 0);
        a_one("t5_after", pk3(2, 2, 2), 1'b0, 6);

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 1500; i++) begin
            a_in_valid  = ($urandom % 4) != 0;
            a_in_ops    = (A_N*A_W)'($urandom);
            a_in_signed = 1'($urandom);
            a_out_ready = ($urandom % 3) != 0;
            rst         = ($urandom % 250) == 0;
            tick();
        end
        rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_q_empty", a_q.size(), 0);
        chk("rand_idle", a_out_valid, 0);

        // Five-operand instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b_one("t6_max", {5{8'hFF}}, 1'b0, 1275);
        for (int i = 0; i < 3; i++) begin
            bops = {$urandom, $urandom};
            bsg  = 1'($urandom);
            b_one("t6_rand", bops, bsg, ref_sum(64'(bops), bsg, B_W, B_N, B_OW));
        end
        b_one("t6_min_s", {5{8'h80}}, 1'b1, 2048 - 640);
`ifdef MULTI_SUM_PIPE_COUNT_EN
        chk("t6_cnt5", b_txn_count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cnt_rst", b_txn_count, 0);
        b_in_valid = 1'b1; b_in_ops = {5{8'h01}}; b_in_signed = 1'b0; b_out_ready = 1'b1;
        repeat (4) tick();
        b_in_valid = 1'b0;
        repeat (4) tick();
        chk("t6_cnt4", b_txn_count, 4);
        b_in_valid = 1'b1;
        repeat (65531) tick();
        b_in_valid = 1'b0;
        repeat (4) tick();
        chk("t6_cnt_ffff", b_txn_count, 16'hFFFF);
        b_one("t6_wrap_txn", {5{8'h02}}, 1'b0, 10);
        chk("t6_cnt_wrap", b_txn_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
